// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared types and constants for the instruction fetch stage
package if_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] next_pc;
  } fifo_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction memory req/ack bus between fetch unit and memory
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;
  logic            IMem_Req;
  logic [XLEN-1:0] IMem_Addr;
  logic            IMem_Ack;
  logic [XLEN-1:0] IMem_Data;
  modport master(output IMem_Req, IMem_Addr, input IMem_Ack, IMem_Data);
  modport slave(input IMem_Req, IMem_Addr, output IMem_Ack, IMem_Data);
endinterface

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: prefetch FIFO of {instr, next_pc} with push/pop/clear where clear wins
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  fifo_entry_t            din,
  output fifo_entry_t            dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fifo_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge Clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, fetch FSM and prefetch FIFO feeding the IF/ID register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  if_fetch_unit_if.master        imem,
  input  logic                   IFIDWrite,
  input  logic                   FlushSignal,
  input  logic                   BranchTaken,
  input  logic [XLEN-1:0]        BranchTarget,
  output logic [XLEN-1:0]        Instruction_Out,
  output logic [XLEN-1:0]        NextInstruction_Out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t    state;
  logic [XLEN-1:0] pc, addr_q;
  fifo_entry_t     head;
  logic [CW-1:0]   count;
  logic            empty, ack, push, pop, space;
  assign ack   = imem.IMem_Ack;
  assign empty = count == '0;
  assign space = count < CW'(FIFO_DEPTH);
  assign push  = state == WAIT && ack && !BranchTaken;
  assign pop   = !empty && !IFIDWrite && !FlushSignal && !BranchTaken;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (state != DISCARD) addr_q <= pc;
      if (BranchTaken) pc <= BranchTarget & ~32'h3;
      else if (push) pc <= pc + PC_INCR;
      if (state != FETCH && ack) state <= FETCH;
      else if (state == WAIT && BranchTaken) state <= DISCARD;
      else if (state == FETCH && !BranchTaken && space) state <= WAIT;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (BranchTaken),
    .push    (push),
    .pop     (pop),
    .din     ('{instr: imem.IMem_Data, next_pc: pc + PC_INCR}),
    .dout    (head),
    .count   (count)
  );
  assign imem.IMem_Req     = state != FETCH;
  assign imem.IMem_Addr    = state == DISCARD ? addr_q : pc;
  assign Instruction_Out     = empty ? NOP_INSTR : head.instr;
  assign NextInstruction_Out = empty ? NOP_INSTR : head.next_pc;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of the fetch unit against a latency-configurable memory
module tb_if_fetch_unit;
  logic        Clk, Reset_n, IFIDWrite, FlushSignal, BranchTaken;
  logic [31:0] BranchTarget, instr_a, next_a, instr_b, next_b;
  logic [3:0]  lat, wcnt_a, wcnt_b;
  int          checks, failures;
  if_fetch_unit_if bus_a();
  if_fetch_unit_if bus_b();
  if_fetch_unit dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .imem(bus_a), .IFIDWrite(IFIDWrite),
    .FlushSignal(FlushSignal), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Instruction_Out(instr_a), .NextInstruction_Out(next_a)
  );
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .imem(bus_b), .IFIDWrite(IFIDWrite),
    .FlushSignal(FlushSignal), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Instruction_Out(instr_b), .NextInstruction_Out(next_b)
  );
  assign bus_a.IMem_Ack  = bus_a.IMem_Req && wcnt_a == lat;
  assign bus_a.IMem_Data = bus_a.IMem_Addr ^ 32'hDEAD_0000;
  assign bus_b.IMem_Ack  = bus_b.IMem_Req && wcnt_b == lat;
  assign bus_b.IMem_Data = bus_b.IMem_Addr ^ 32'hDEAD_0000;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wcnt_a <= '0;
      wcnt_b <= '0;
    end else begin
      wcnt_a <= (bus_a.IMem_Req && !bus_a.IMem_Ack) ? wcnt_a + 4'd1 : '0;
      wcnt_b <= (bus_b.IMem_Req && !bus_b.IMem_Ack) ? wcnt_b + 4'd1 : '0;
    end
  end
  initial Clk = 0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic do_reset;
    Reset_n = 0;
    tick;
    Reset_n = 1;
  endtask
  initial begin
    checks = 0; failures = 0;
    Reset_n = 0; IFIDWrite = 0; FlushSignal = 0; BranchTaken = 0; BranchTarget = 0; lat = 0;
    @(negedge Clk);
    chk("rst_req", 32'(bus_a.IMem_Req), 0);
    chk("rst_addr", bus_a.IMem_Addr, 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_next", next_a, 0);
    chk("rst_addr_b", bus_b.IMem_Addr, 32'hFFFF_FFFC);
    tick;
    Reset_n = 1;
    tick; chk("t1_req", 32'(bus_a.IMem_Req), 1); chk("t1_addr0", bus_a.IMem_Addr, 0); chk("t1_empty", instr_a, 0);
    tick; chk("t1_i0", instr_a, 32'hDEAD_0000); chk("t1_n0", next_a, 32'h4); chk("t1_idle", 32'(bus_a.IMem_Req), 0);
    tick; chk("t1_bubble", instr_a, 0); chk("t1_addr4", bus_a.IMem_Addr, 32'h4);
    tick; chk("t1_i1", instr_a, 32'hDEAD_0004); chk("t1_n1", next_a, 32'h8);
    tick; chk("t1_addr8", bus_a.IMem_Addr, 32'h8);
    tick; chk("t1_i2", instr_a, 32'hDEAD_0008); chk("t1_n2", next_a, 32'hC);
    IFIDWrite = 1;
    do_reset;
    tick; tick; tick;
    tick; chk("t2_head", instr_a, 32'hDEAD_0000); chk("t2_next", next_a, 32'h4);
    tick; chk("t2_full_req", 32'(bus_a.IMem_Req), 0);
    tick; chk("t2_full_req2", 32'(bus_a.IMem_Req), 0); chk("t2_hold", instr_a, 32'hDEAD_0000);
    IFIDWrite = 0;
    tick; chk("t2_pop", instr_a, 32'hDEAD_0004); chk("t2_pop_n", next_a, 32'h8); chk("t2_req_lag", 32'(bus_a.IMem_Req), 0);
    tick; chk("t2_resume", 32'(bus_a.IMem_Req), 1); chk("t2_addr8", bus_a.IMem_Addr, 32'h8);
    lat = 3;
    do_reset;
    tick; chk("t3_noack", 32'(bus_a.IMem_Ack), 0);
    BranchTaken = 1; BranchTarget = 32'h100;
    tick; BranchTaken = 0;
    chk("t3_req", 32'(bus_a.IMem_Req), 1); chk("t3_hold0", bus_a.IMem_Addr, 0); chk("t3_out0", instr_a, 0);
    tick; chk("t3_hold1", bus_a.IMem_Addr, 0);
    tick; chk("t3_ack", 32'(bus_a.IMem_Ack), 1); chk("t3_hold2", bus_a.IMem_Addr, 0);
    tick; chk("t3_drop", instr_a, 0); chk("t3_idle", 32'(bus_a.IMem_Req), 0); chk("t3_pc", bus_a.IMem_Addr, 32'h100);
    tick; chk("t3_refetch", 32'(bus_a.IMem_Req), 1); chk("t3_addr100", bus_a.IMem_Addr, 32'h100); chk("t3_out1", next_a, 0);
    lat = 0; IFIDWrite = 1;
    do_reset;
    tick; tick;
    tick; chk("t4_ack", 32'(bus_a.IMem_Ack), 1); chk("t4_addr4", bus_a.IMem_Addr, 32'h4);
    IFIDWrite = 0; BranchTaken = 1; BranchTarget = 32'h203;
    tick; BranchTaken = 0;
    chk("t4_clear", instr_a, 0); chk("t4_idle", 32'(bus_a.IMem_Req), 0); chk("t4_pc", bus_a.IMem_Addr, 32'h200);
    tick; chk("t4_req", 32'(bus_a.IMem_Req), 1); chk("t4_addr", bus_a.IMem_Addr, 32'h200);
    tick; chk("t4_head", instr_a, 32'hDEAD_0200); chk("t4_next", next_a, 32'h204);
    FlushSignal = 1;
    do_reset;
    tick;
    tick; chk("t5_head", instr_a, 32'hDEAD_0000);
    tick; chk("t5_kept", instr_a, 32'hDEAD_0000); chk("t5_req", 32'(bus_a.IMem_Req), 1); chk("t5_addr", bus_a.IMem_Addr, 32'h4);
    FlushSignal = 0;
    tick; chk("t5_pop", instr_a, 32'hDEAD_0004); chk("t5_next", next_a, 32'h8);
    IFIDWrite = 1;
    do_reset;
    chk("t6_rst_addr", bus_b.IMem_Addr, 32'hFFFF_FFFC);
    tick; chk("t6_req", 32'(bus_b.IMem_Req), 1); chk("t6_addr", bus_b.IMem_Addr, 32'hFFFF_FFFC);
    tick; chk("t6_instr", instr_b, 32'h2152_FFFC); chk("t6_wrap_next", next_b, 32'h0);
    tick; chk("t6_wrap_addr", bus_b.IMem_Addr, 32'h0); chk("t6_wait", 32'(bus_b.IMem_Req), 1);
    Reset_n = 0;
    #1;
    chk("t6_async_req", 32'(bus_b.IMem_Req), 0);
    chk("t6_async_instr", instr_b, 0);
    chk("t6_async_next", next_b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
